gcd_sched: RTL and testbench
============================

# gcd_sched

Two-client scheduler and sequencer for the 8-bit subtractive GCD datapath. It arbitrates between two requesters with round-robin priority and muxes the winner's operands onto the datapath. It drives the datapath load/select/output-enable controls from the comparator flags, and returns a one-cycle done pulse, plus error status, to the served client. It sits between the client ports and one shared GCD datapath instance.

## Interface
- W, 8: operand width; must match the datapath.
- MAX_ITER, 255: subtraction-count limit before a timeout error.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  client request; held high with stable operands until that client's done.
- a0, b0, a1, b1  in  W  client operands.
- gnt0, gnt1  out  1  client owns the datapath; high from LOAD through DONE.
- done0, done1  out  1  one-cycle completion pulse to the served client.
- err  out  1  valid with done: 1 means zero operand or timeout, and the result is invalid.
- dp_a, dp_b  out  W  operands of the granted client; 0 when no grant.
- asel, bsel  out  1  datapath mux select: 1 selects the external operand, 0 selects the subtractor.
- aload, bload, out_en  out  1  datapath register enables.
- gt, lt, eq  in  1  datapath comparator: A>B, A<B, A==B, from the registered A/B.

## Operation
- States: IDLE, LOAD, CALC, DONE, ERR.
- IDLE:
  - Sample req0/req1.
  - With one request, grant it. With both, grant the client not served last.
  - The last-served pointer resets to 1, so client 0 wins the first tie.
  - If the winner's a or b is 0, go to ERR and skip the datapath. Otherwise go to LOAD.
- LOAD: asel=bsel=1 and aload=bload=1. The datapath captures dp_a/dp_b. Clear the iteration counter. Go to CALC.
- CALC (evaluated every cycle):
  - eq: out_en=1, go to DONE.
  - gt: asel=0, aload=1, so A<=A-B. Counter+1.
  - lt: bsel=0, bload=1, so B<=B-A. Counter+1.
  - Counter==MAX_ITER without eq: go to ERR, out_en=0.
  - Flag priority is eq > gt > lt. No flag set: treat as timeout and go to ERR.
- DONE: done of the granted client =1, err=0. The datapath out register holds the GCD. Update the pointer and go to IDLE.
- ERR: done of the granted client =1, err=1. Update the pointer and go to IDLE.
- A client must drop req on the edge following its done pulse. A req still high in IDLE is a new request.
- Outputs:
  - done, err and all datapath enables are Moore outputs of the state register.
  - dp_a/dp_b are combinational from gnt.
  - Enables are 0 in every state not listed above.

## Timing
- Reset values: gnt0/1=0, done0/1=0, err=0, aload=bload=out_en=0, asel=bsel=0, dp_a=dp_b=0. State is IDLE and pointer=1.
- Reset mid-operation aborts the job and issues no done. The partial datapath contents are don't-care.
- Latency from the req-sampled IDLE cycle to the done cycle is N+3 cycles, where N is the number of subtractions. For nonzero 8-bit inputs, N ≤ 254.
  - Example gcd(12,8), N=2: c0 IDLE, c1 LOAD, c2 CALC(A=4), c3 CALC(B=4), c4 CALC eq with out_en, c5 DONE, with out=4 valid from c5.
- Zero operand: c0 IDLE, c1 ERR with done and err. No datapath enable asserts.
- Back-to-back: the client not last served is granted in the IDLE cycle right after DONE/ERR.
- gnt changes only on IDLE→LOAD/ERR and DONE/ERR→IDLE.

## Structure
- gcd_pkg: state encoding constants, the W default and the MAX_ITER default.
- Sub-module gcd_rr_arb2: 2-way round-robin pick and last-served pointer register. Inputs are req0/req1 and an update strobe; the output is the winner index.
- The top contains the FSM, the iteration counter (8 bits), the operand mux and the control decode.

## Test plan
- Single job: client 0 requests a0=12, b0=8. Require gnt0 c1–c5, done0 at c5, err=0, datapath out=4.
- Worst case: a1=255, b1=1. Require 254 subtractions, done1 at cycle 257 after sampling, out=1, err=0.
- Contention: req0 and req1 rise together, repeated twice. Require client 0 served first, then client 1, then client 0, with no idle gap beyond one IDLE cycle between jobs.
- Zero operand: a0=0, b0=9. Require done0 and err together one cycle after sampling. Require aload, bload and out_en never asserted.
- Timeout: use a datapath stub that holds gt=1. Require ERR after exactly MAX_ITER subtractions, then done with err=1.
- Reset mid-CALC: drop rst during gcd(200,3). Require all outputs to 0 immediately. Require no done. A fresh req0 afterwards completes correctly.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default sizing for the GCD scheduler.
package gcd_pkg;
  localparam int W_DEF = 8;
  localparam int MAX_ITER_DEF = 255;
  typedef enum logic [2:0] {IDLE, LOAD, CALC, DONE, ERR} state_t;
endpackage

// File: rtl/gcd_rr_arb2.sv
// gcd_rr_arb2: two-way round-robin pick with a last-served pointer.
module gcd_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic served,
  output logic win
);
  logic ptr;
  assign win = (req0 && req1) ? !ptr : req1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b1;
    else if (upd) ptr <= served;
endmodule

// File: rtl/gcd_sched.sv
// gcd_sched: arbitrates two clients onto one subtractive GCD datapath and sequences it.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic         asel,
  output logic         bsel,
  output logic         aload,
  output logic         bload,
  output logic         out_en,
  input  logic         gt,
  input  logic         lt,
  input  logic         eq
);
  state_t state;
  logic sel, win, upd, calc, lim, fin;
  logic [7:0] cnt;
  logic [W-1:0] wa, wb;
  assign wa = win ? a1 : a0;
  assign wb = win ? b1 : b0;
  assign upd = fin;
  gcd_rr_arb2 u_arb (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .upd(upd), .served(sel), .win(win)
  );
  always_comb begin
    calc = state == CALC;
    fin = state == DONE || state == ERR;
    lim = cnt == 8'(MAX_ITER);
    gnt0 = state != IDLE && !sel;
    gnt1 = state != IDLE && sel;
    dp_a = gnt1 ? a1 : gnt0 ? a0 : '0;
    dp_b = gnt1 ? b1 : gnt0 ? b0 : '0;
    asel = state == LOAD;
    bsel = state == LOAD;
    // eq outranks gt outranks lt; reaching the limit suppresses the subtract
    aload = state == LOAD || (calc && !eq && gt && !lim);
    bload = state == LOAD || (calc && !eq && !gt && lt && !lim);
    out_en = calc && eq;
    done0 = fin && !sel;
    done1 = fin && sel;
    err = state == ERR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= 1'b0;
      cnt <= '0;
    end else
      case (state)
        IDLE:
          if (req0 || req1) begin
            sel <= win;
            state <= (wa == '0 || wb == '0) ? ERR : LOAD;
          end
        LOAD: begin
          cnt <= '0;
          state <= CALC;
        end
        CALC:
          if (eq) state <= DONE;
          else if (lim || !(gt || lt)) state <= ERR;
          else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: directed checks of gcd_sched against a behavioural datapath.
module tb_gcd_sched;
  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, dp_a, dp_b;
  logic gnt0, gnt1, done0, done1, err, asel, bsel, aload, bload, out_en;
  logic gt, lt, eq, stub = 0;
  logic [7:0] ra = 0, rb = 0, ro = 0;
  int n_chk = 0, n_fail = 0;
  int na = 0, nb = 0, no = 0, nd = 0, ng0 = 0;
  int lat, who, s_na, s_nb, s_no, s_nd, s_ng0;

  gcd_sched dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .dp_a(dp_a), .dp_b(dp_b), .asel(asel), .bsel(bsel),
    .aload(aload), .bload(bload), .out_en(out_en),
    .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  assign gt = stub ? 1'b1 : ra > rb;
  assign lt = stub ? 1'b0 : ra < rb;
  assign eq = stub ? 1'b0 : ra == rb;
  always @(posedge clk) begin
    if (aload) ra <= asel ? dp_a : ra - rb;
    if (bload) rb <= bsel ? dp_b : rb - ra;
    if (out_en) ro <= ra;
  end
  always @(negedge clk) begin
    if (aload) na++;
    if (bload) nb++;
    if (out_en) no++;
    if (done0 || done1) nd++;
    if (gnt0) ng0++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    s_na = na; s_nb = nb; s_no = no; s_nd = nd; s_ng0 = ng0;
  endtask

  task automatic job(input int c, input logic [7:0] a, input logic [7:0] b, input int budget, output int l);
    if (c == 0) begin a0 = a; b0 = b; req0 = 1; end
    else begin a1 = a; b1 = b; req1 = 1; end
    l = 0;
    do begin tick(); l++; end while (!(c == 0 ? done0 : done1) && l < budget);
  endtask

  task automatic serve(output int w, output int l);
    l = 0;
    do begin tick(); l++; end while (!done0 && !done1 && l < 300);
    w = done1 ? 1 : 0;
    if (w == 0) req0 = 0; else req1 = 0;
  endtask

  function automatic int outs;
    return int'({gnt0, gnt1, done0, done1, err, asel, bsel, aload, bload, out_en});
  endfunction

  initial begin
    a0 = 8'd7; b0 = 8'd3; req0 = 1;
    tick(); tick();
    chk("rst_ctl", outs(), 0);
    chk("rst_dp_a", int'(dp_a), 0);
    chk("rst_dp_b", int'(dp_b), 0);
    req0 = 0;
    rst_n = 1;
    tick();
    chk("idle_ctl", outs(), 0);

    snap();
    job(0, 8'd12, 8'd8, 50, lat);
    chk("single_lat", lat, 5);
    chk("single_err", int'(err), 0);
    chk("single_out", int'(ro), 4);
    chk("single_gnt_at_done", int'(gnt0), 1);
    req0 = 0;
    tick();
    chk("single_done_pulse", int'(done0), 0);
    chk("single_gnt_drop", int'(gnt0), 0);
    chk("single_gnt_cycles", ng0 - s_ng0, 5);
    chk("single_aload", na - s_na, 2);
    chk("single_bload", nb - s_nb, 2);
    chk("single_out_en", no - s_no, 1);

    snap();
    job(0, 8'd0, 8'd9, 20, lat);
    chk("zero_lat", lat, 1);
    chk("zero_err", int'(err), 1);
    req0 = 0;
    tick();
    chk("zero_enables", (na - s_na) + (nb - s_nb) + (no - s_no), 0);
    chk("zero_gnt_cycles", ng0 - s_ng0, 1);

    snap();
    job(1, 8'd255, 8'd1, 400, lat);
    chk("worst_lat", lat, 257);
    chk("worst_err", int'(err), 0);
    chk("worst_out", int'(ro), 1);
    req1 = 0;
    tick();
    chk("worst_aload", na - s_na, 255);
    chk("worst_bload", nb - s_nb, 1);

    a0 = 8'd12; b0 = 8'd8; a1 = 8'd9; b1 = 8'd6;
    for (int r = 0; r < 2; r++) begin
      if (r > 0) tick();
      req0 = 1; req1 = 1;
      serve(who, lat);
      chk($sformatf("cont%0d_first_who", r), who, 0);
      chk($sformatf("cont%0d_first_lat", r), lat, 5);
      chk($sformatf("cont%0d_first_out", r), int'(ro), 4);
      serve(who, lat);
      chk($sformatf("cont%0d_second_who", r), who, 1);
      chk($sformatf("cont%0d_second_lat", r), lat, 6);
      chk($sformatf("cont%0d_second_out", r), int'(ro), 3);
    end
    tick();

    stub = 1;
    snap();
    job(0, 8'd5, 8'd7, 400, lat);
    chk("tmo_lat", lat, 258);
    chk("tmo_err", int'(err), 1);
    req0 = 0;
    stub = 0;
    tick();
    chk("tmo_aload", na - s_na, 256);
    chk("tmo_out_en", no - s_no, 0);

    a0 = 8'd200; b0 = 8'd3; req0 = 1;
    repeat (10) tick();
    chk("mid_busy", int'(gnt0), 1);
    snap();
    rst_n = 0;
    #1;
    chk("mid_rst_ctl", outs(), 0);
    chk("mid_rst_dp", int'(dp_a) + int'(dp_b), 0);
    req0 = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("mid_rst_no_done", nd - s_nd, 0);
    job(0, 8'd200, 8'd3, 400, lat);
    chk("fresh_lat", lat, 71);
    chk("fresh_err", int'(err), 0);
    chk("fresh_out", int'(ro), 1);
    req0 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
